// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for the parametrised FIFO.
package fifo_pkg;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, synchronous write, combinational read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised show-ahead synchronous FIFO with level flags and error reporting.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow sticky until clr or reset.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   write,
    input  logic [WIDTH-1:0]       din,
    input  logic                   read,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int PW    = ptr_w(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_cfg
        $error("fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PW-1:0]    wptr, rptr;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_ok, rd_ok, ovf_set, unf_set;

    // clr masks every request so a flush never writes or raises an error
    always_comb begin
        wr_ok     = write & (!full | read) & !clr;
        rd_ok     = read & !empty & !clr;
        ovf_set   = write & full & !read & !clr;
        unf_set   = read & empty & !clr;
        count_nxt = clr ? '0 : count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wptr         <= clr ? '0 : wptr + PW'(wr_ok);
            rptr         <= clr ? '0 : rptr + PW'(rd_ok);
            count        <= count_nxt;
            full         <= count_nxt == FULL_C;
            empty        <= count_nxt == '0;
            almost_full  <= count_nxt >= AF_C;
            almost_empty <= count_nxt <= AE_C;
`ifdef FIFO_STICKY_ERR_EN
            overflow     <= !clr & (overflow | ovf_set);
            underflow    <= !clr & (underflow | unf_set);
`else
            overflow     <= ovf_set;
            underflow    <= unf_set;
`endif
        end
    end

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wptr),
        .wdata(din),
        .raddr(rptr),
        .rdata(dout)
    );
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed and random checks of fifo_param against a queue model.
module tb_fifo_param;
`ifdef FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, write = 1'b0, read = 1'b0;
    logic [7:0] din = '0, dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int tests = 0, fails = 0;
    logic [7:0] q[$];
    bit e_ovf = 1'b0, e_unf = 1'b0;

    fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .write(write), .din(din), .read(read),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), q.size());
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
        chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(e_unf));
        if (q.size() > 0) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
    endtask

    // One clock: drive on negedge, advance the model at the edge, check #1 later
    task automatic cyc(input string tag, input bit w, input bit r, input bit c, input logic [7:0] d);
        bit was_full, was_empty, ov, un;
        @(negedge clk);
        write = w; read = r; clr = c; din = d;
        was_full  = q.size() == DEPTH;
        was_empty = q.size() == 0;
        @(posedge clk);
        if (c) begin
            q.delete();
            e_ovf = 1'b0;
            e_unf = 1'b0;
        end else begin
            ov = w && was_full && !r;
            un = r && was_empty;
            if (r && !was_empty) void'(q.pop_front());
            if (w && (!was_full || r)) q.push_back(d);
            e_ovf = STICKY ? (e_ovf | ov) : ov;
            e_unf = STICKY ? (e_unf | un) : un;
        end
        #1 check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        q.delete();
        e_ovf = 1'b0;
        e_unf = 1'b0;
        check_all(tag);
        @(negedge clk);
        write = 0; read = 0; clr = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        #12 do_reset("reset");
        cyc("idle", 0, 0, 0, 8'h00);
        cyc("idle", 0, 0, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cyc("fill", 1, 0, 0, 8'(i));
            if (i == 2) chk("fill.ae_low_after3", 32'(almost_empty), 0);
            if (i == 13) chk("fill.af_after14", 32'(almost_full), 1);
        end
        chk("fill.full", 32'(full), 1);
        cyc("ovf", 1, 0, 0, 8'hAA);
        chk("ovf.pulse", 32'(overflow), 1);
        cyc("ovf_after", 0, 0, 0, 8'h00);
        cyc("full_wr_rd", 1, 1, 0, 8'h55);
        chk("full_wr_rd.count", 32'(count), 16);
        chk("full_wr_rd.head", 32'(dout), 8'h01);
        for (int i = 0; i < 16; i++) cyc("drain", 0, 1, 0, 8'h00);
        chk("drain.empty", 32'(empty), 1);
        cyc("unf", 0, 1, 0, 8'h00);
        chk("unf.pulse", 32'(underflow), 1);
        cyc("empty_wr_rd", 1, 1, 0, 8'h33);
        chk("empty_wr_rd.dout", 32'(dout), 8'h33);
        chk("empty_wr_rd.underflow", 32'(underflow), 1);
        cyc("pop33", 0, 1, 0, 8'h00);
        cyc("clr_err", 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cyc("pre_wrap", 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            cyc("wrap_wr", 1, 0, 0, 8'($urandom));
            cyc("wrap_rd", 0, 1, 0, 8'h00);
        end
        for (int i = 0; i < 3; i++) cyc("post_wrap", 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) cyc("to5", 1, 0, 0, 8'(8'h40 + i));
        cyc("clr5", 1, 0, 1, 8'hEE);
        chk("clr5.count", 32'(count), 0);
        for (int i = 0; i < 16; i++) cyc("refill", 1, 0, 0, 8'($urandom));
        cyc("ovf2", 1, 0, 0, 8'hAA);
        for (int i = 0; i < 10; i++) cyc("hold", 0, 0, 0, 8'h00);
        chk("hold.overflow", 32'(overflow), 32'(STICKY));
        cyc("clr_sticky", 0, 0, 1, 8'h00);
        chk("clr_sticky.overflow", 32'(overflow), 0);
        for (int i = 0; i < 600; i++) begin
            int mode = int'($urandom_range(0, 3));
            bit w = mode == 0 ? 1'($urandom_range(0, 7) != 0) : mode == 1 ? 1'($urandom_range(0, 7) == 0) : 1'($urandom);
            bit r = mode == 1 ? 1'($urandom_range(0, 7) != 0) : mode == 0 ? 1'($urandom_range(0, 7) == 0) : 1'($urandom);
            cyc("rand", w, r, 1'($urandom_range(0, 63) == 0), 8'($urandom));
        end
        for (int i = 0; i < 7; i++) cyc("pre_rst", 1, 0, 0, 8'($urandom));
        @(posedge clk);
        #2 do_reset("midrst");
        cyc("after_rst", 1, 0, 0, 8'h77);
        chk("after_rst.dout", 32'(dout), 8'h77);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
